// File: rtl/control_pkg.sv
// Shared constants for the pipelined MIPS control path: opcode/funct
// encodings, ALU operation codes, control-bus field positions and the
// all-zero bubble words loaded into stage registers.
package control_pkg;

  // Primary opcodes (instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LB    = 6'h20;
  localparam logic [5:0] OP_LH    = 6'h21;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_LBU   = 6'h24;
  localparam logic [5:0] OP_LHU   = 6'h25;
  localparam logic [5:0] OP_SB    = 6'h28;
  localparam logic [5:0] OP_SH    = 6'h29;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type function codes (instr[5:0])
  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06;
  localparam logic [5:0] FN_SRAV = 6'h07;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_JALR = 6'h09;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  // ALU operation codes
  typedef enum logic [3:0] {
    ALU_SLL  = 4'h0, ALU_SRL  = 4'h1, ALU_SRA  = 4'h2, ALU_ADD  = 4'h3,
    ALU_SUB  = 4'h4, ALU_AND  = 4'h5, ALU_OR   = 4'h6, ALU_XOR  = 4'h7,
    ALU_NOR  = 4'h8, ALU_SLT  = 4'h9, ALU_LUI  = 4'hA, ALU_SLLV = 4'hB,
    ALU_SRLV = 4'hC, ALU_SRAV = 4'hD, ALU_LINK = 4'hE
  } alu_code_e;

  // Execute flag field positions; the flags sit above ALUCode in the EX bus
  localparam int EXF_REGDST  = 4;
  localparam int EXF_ALUSRC1 = 3;
  localparam int EXF_ALUSRC2 = 2;
  localparam int EXF_JUMP    = 1;
  localparam int EXF_JR      = 0;

  // Memory bus field positions
  localparam int MEMB_BRANCH = 2;
  localparam int MEMB_READ   = 1;
  localparam int MEMB_WRITE  = 0;

  // Write-back bus field positions
  localparam int WBB_REGWRITE = 1;
  localparam int WBB_MEMTOREG = 0;

  // Bubble words: every control bit low
  localparam logic [4:0] BUBBLE_EXF = 5'b0;
  localparam logic [2:0] BUBBLE_MEM = 3'b0;
  localparam logic [1:0] BUBBLE_WB  = 2'b0;

endpackage

// File: rtl/control_decoder.sv
// Combinational ID-stage decoder: opcode/funct to execute flags, ALU code,
// memory and write-back controls, destination register and illegal flag.
// o_uses_rt marks instructions that read rt as a source (R-type, branch,
// store), which the load-use detector needs.
module control_decoder
  import control_pkg::*;
#(
  parameter int NB_OPCODE   = 6,
  parameter int NB_REG      = 5,
  parameter int NB_ALU_CODE = 4
) (
  input  logic                   i_valid,
  input  logic [NB_OPCODE-1:0]   i_opcode,
  input  logic [NB_OPCODE-1:0]   i_funct,
  input  logic [NB_REG-1:0]      i_rt,
  input  logic [NB_REG-1:0]      i_rd,
  output logic [4:0]             o_exf,
  output logic [NB_ALU_CODE-1:0] o_alu_code,
  output logic [2:0]             o_mem,
  output logic [1:0]             o_wb,
  output logic [NB_REG-1:0]      o_wreg,
  output logic                   o_illegal,
  output logic                   o_uses_rt
);

  // Decode table; anything not valid or not recognised stays a bubble
  always_comb begin
    o_exf      = BUBBLE_EXF;
    o_mem      = BUBBLE_MEM;
    o_wb       = BUBBLE_WB;
    o_alu_code = '0;
    o_wreg     = '0;
    o_illegal  = 1'b0;
    o_uses_rt  = 1'b0;
    if (i_valid) begin
      case (i_opcode)
        OP_RTYPE: begin
          o_exf[EXF_REGDST]  = 1'b1;
          o_wb[WBB_REGWRITE] = 1'b1;
          o_wreg             = i_rd;
          o_uses_rt          = 1'b1;
          case (i_funct)
            FN_SLL:  begin o_exf[EXF_ALUSRC1] = 1'b1; o_alu_code = NB_ALU_CODE'(ALU_SLL); end
            FN_SRL:  begin o_exf[EXF_ALUSRC1] = 1'b1; o_alu_code = NB_ALU_CODE'(ALU_SRL); end
            FN_SRA:  begin o_exf[EXF_ALUSRC1] = 1'b1; o_alu_code = NB_ALU_CODE'(ALU_SRA); end
            FN_SLLV: o_alu_code = NB_ALU_CODE'(ALU_SLLV);
            FN_SRLV: o_alu_code = NB_ALU_CODE'(ALU_SRLV);
            FN_SRAV: o_alu_code = NB_ALU_CODE'(ALU_SRAV);
            FN_JR: begin
              o_exf[EXF_JR]      = 1'b1;
              o_wb[WBB_REGWRITE] = 1'b0;
              o_wreg             = '0;
            end
            FN_JALR: begin
              o_exf[EXF_JR] = 1'b1;
              o_alu_code    = NB_ALU_CODE'(ALU_LINK);
            end
            FN_ADD, FN_ADDU: o_alu_code = NB_ALU_CODE'(ALU_ADD);
            FN_SUB, FN_SUBU: o_alu_code = NB_ALU_CODE'(ALU_SUB);
            FN_AND:          o_alu_code = NB_ALU_CODE'(ALU_AND);
            FN_OR:           o_alu_code = NB_ALU_CODE'(ALU_OR);
            FN_XOR:          o_alu_code = NB_ALU_CODE'(ALU_XOR);
            FN_NOR:          o_alu_code = NB_ALU_CODE'(ALU_NOR);
            FN_SLT, FN_SLTU: o_alu_code = NB_ALU_CODE'(ALU_SLT);
            default:         o_alu_code = '0;
          endcase
        end
        OP_J: o_exf[EXF_JUMP] = 1'b1;
        OP_JAL: begin
          o_exf[EXF_JUMP]    = 1'b1;
          o_wb[WBB_REGWRITE] = 1'b1;
          o_wreg             = '1;
          o_alu_code         = NB_ALU_CODE'(ALU_LINK);
        end
        OP_BEQ, OP_BNE: begin
          o_mem[MEMB_BRANCH] = 1'b1;
          o_alu_code         = NB_ALU_CODE'(ALU_SUB);
          o_uses_rt          = 1'b1;
        end
        OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: begin
          o_exf[EXF_ALUSRC2] = 1'b1;
          o_mem[MEMB_READ]   = 1'b1;
          o_wb[WBB_REGWRITE] = 1'b1;
          o_wb[WBB_MEMTOREG] = 1'b1;
          o_wreg             = i_rt;
          o_alu_code         = NB_ALU_CODE'(ALU_ADD);
        end
        OP_SB, OP_SH, OP_SW: begin
          o_exf[EXF_ALUSRC2] = 1'b1;
          o_mem[MEMB_WRITE]  = 1'b1;
          o_alu_code         = NB_ALU_CODE'(ALU_ADD);
          o_uses_rt          = 1'b1;
        end
        OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_SLTI, OP_LUI: begin
          o_exf[EXF_ALUSRC2] = 1'b1;
          o_wb[WBB_REGWRITE] = 1'b1;
          o_wreg             = i_rt;
          case (i_opcode)
            OP_ANDI: o_alu_code = NB_ALU_CODE'(ALU_AND);
            OP_ORI:  o_alu_code = NB_ALU_CODE'(ALU_OR);
            OP_XORI: o_alu_code = NB_ALU_CODE'(ALU_XOR);
            OP_SLTI: o_alu_code = NB_ALU_CODE'(ALU_SLT);
            OP_LUI:  o_alu_code = NB_ALU_CODE'(ALU_LUI);
            default: o_alu_code = NB_ALU_CODE'(ALU_ADD);
          endcase
        end
        default: o_illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/control_pipe.sv
// Pipelined control path: decodes the IF/ID instruction and carries its
// controls through ID/EX, EX/MEM and MEM/WB. Generates load-use stall,
// IF/ID squash on taken branches and jumps, and global halt.
// i_valid qualifies the IF/ID contents: when low the instruction is
// treated as a bubble and can neither stall nor flush.
// Precedence on each edge: reset > halt > flush > load-use > normal.
module control_pipe
  import control_pkg::*;
#(
  parameter int NB_OPCODE   = 6,
  parameter int NB_REG      = 5,
  parameter int NB_ALU_CODE = 4,
  parameter int HAZARD_EN   = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_valid,
  input  logic [NB_OPCODE-1:0]     i_opcode,
  input  logic [NB_OPCODE-1:0]     i_funct,
  input  logic [NB_REG-1:0]        i_rs,
  input  logic [NB_REG-1:0]        i_rt,
  input  logic [NB_REG-1:0]        i_rd,
  input  logic                     i_flush,
  input  logic                     i_halt,
  output logic [5+NB_ALU_CODE-1:0] o_ex_bus,
  output logic [2:0]               o_ex_mem_bus,
  output logic [NB_REG-1:0]        o_ex_wreg,
  output logic                     o_ex_regwrite,
  output logic [1:0]               o_wb_bus,
  output logic [NB_REG-1:0]        o_wb_wreg,
  output logic                     o_stall,
  output logic                     o_pc_write,
  output logic                     o_ifid_write,
  output logic                     o_ifid_flush,
  output logic                     o_illegal
);

  localparam bit HAZARD_ON = (HAZARD_EN != 0);

  // Decode results
  logic [4:0]             dec_exf;
  logic [NB_ALU_CODE-1:0] dec_alu;
  logic [2:0]             dec_mem;
  logic [1:0]             dec_wb;
  logic [NB_REG-1:0]      dec_wreg;
  logic                   dec_illegal;
  logic                   dec_uses_rt;

  // ID/EX stage
  logic [4:0]             idex_exf;
  logic [NB_ALU_CODE-1:0] idex_alu;
  logic [2:0]             idex_mem;
  logic [1:0]             idex_wb;
  logic [NB_REG-1:0]      idex_wreg;
  logic                   idex_illegal;

  // EX/MEM stage
  logic [2:0]             exmem_mem;
  logic [1:0]             exmem_wb;
  logic [NB_REG-1:0]      exmem_wreg;

  // MEM/WB stage
  logic [1:0]             memwb_wb;
  logic [NB_REG-1:0]      memwb_wreg;

  logic load_use;
  logic stall;
  logic dec_redirect;

  control_decoder #(
    .NB_OPCODE   (NB_OPCODE),
    .NB_REG      (NB_REG),
    .NB_ALU_CODE (NB_ALU_CODE)
  ) u_decoder (
    .i_valid    (i_valid),
    .i_opcode   (i_opcode),
    .i_funct    (i_funct),
    .i_rt       (i_rt),
    .i_rd       (i_rd),
    .o_exf      (dec_exf),
    .o_alu_code (dec_alu),
    .o_mem      (dec_mem),
    .o_wb       (dec_wb),
    .o_wreg     (dec_wreg),
    .o_illegal  (dec_illegal),
    .o_uses_rt  (dec_uses_rt)
  );

  // Load-use detect against the load sitting in ID/EX; a zero destination
  // never matches, so rt=0 / wreg=0 cases cannot stall
  always_comb begin
    load_use = HAZARD_ON && i_valid && idex_mem[MEMB_READ] && (idex_wreg != '0) &&
               ((idex_wreg == i_rs) || (dec_uses_rt && (idex_wreg == i_rt)));
    stall        = load_use && !i_halt && !i_flush;
    dec_redirect = dec_exf[EXF_JUMP] || dec_exf[EXF_JR];
  end

  // Stage register advance with reset/halt/flush/stall precedence
  always_ff @(posedge clk) begin
    if (reset) begin
      idex_exf     <= BUBBLE_EXF;
      idex_alu     <= '0;
      idex_mem     <= BUBBLE_MEM;
      idex_wb      <= BUBBLE_WB;
      idex_wreg    <= '0;
      idex_illegal <= 1'b0;
      exmem_mem    <= BUBBLE_MEM;
      exmem_wb     <= BUBBLE_WB;
      exmem_wreg   <= '0;
      memwb_wb     <= BUBBLE_WB;
      memwb_wreg   <= '0;
    end else if (!i_halt) begin
      if (i_flush || stall) begin
        idex_exf     <= BUBBLE_EXF;
        idex_alu     <= '0;
        idex_mem     <= BUBBLE_MEM;
        idex_wb      <= BUBBLE_WB;
        idex_wreg    <= '0;
        idex_illegal <= 1'b0;
      end else begin
        idex_exf     <= dec_exf;
        idex_alu     <= dec_alu;
        idex_mem     <= dec_mem;
        idex_wb      <= dec_wb;
        idex_wreg    <= dec_wreg;
        idex_illegal <= dec_illegal;
      end
      if (i_flush) begin
        exmem_mem  <= BUBBLE_MEM;
        exmem_wb   <= BUBBLE_WB;
        exmem_wreg <= '0;
      end else begin
        exmem_mem  <= idex_mem;
        exmem_wb   <= idex_wb;
        exmem_wreg <= idex_wreg;
      end
      memwb_wb   <= exmem_wb;
      memwb_wreg <= exmem_wreg;
    end
  end

  // Front-end enables and stage outputs; a stalled jump keeps IF/ID so
  // it is not squashed until it actually leaves ID
  always_comb begin
    o_stall       = stall;
    o_pc_write    = !i_halt && !stall;
    o_ifid_write  = !i_halt && !stall;
    o_ifid_flush  = !i_halt && (i_flush || (dec_redirect && !stall));
    o_ex_bus      = {idex_exf, idex_alu};
    o_ex_mem_bus  = exmem_mem;
    o_ex_wreg     = exmem_wreg;
    o_ex_regwrite = exmem_wb[WBB_REGWRITE];
    o_wb_bus      = memwb_wb;
    o_wb_wreg     = memwb_wreg;
    o_illegal     = idex_illegal;
  end

endmodule
